// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide unit.
//   md_op_t    : M-extension operation, encoded exactly as RV32M funct3
//   md_state_t : sequencer FSM states
//   is_div     : op belongs to the divide/remainder class
//   is_rem     : op returns the remainder rather than the quotient
//   a_signed   : rs1 is interpreted as a signed value for this op
//   b_signed   : rs2 is interpreted as a signed value for this op
// ---------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CALC   = 2'b01,
        ST_FINISH = 2'b10,
        ST_DONE   = 2'b11
    } md_state_t;

    // Divide class covers both quotient and remainder ops.
    function automatic logic is_div(md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
    endfunction

    function automatic logic is_rem(md_op_t op);
        return (op == MD_REM) || (op == MD_REMU);
    endfunction

    // MUL only needs the low half, which is the same for signed and unsigned
    // inputs, so treating it as signed keeps the sign handling uniform.
    function automatic logic a_signed(md_op_t op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic b_signed(md_op_t op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_dp.sv
// ---------------------------------------------------------------------------
// muldiv_dp
// Radix-2 shift/add-subtract datapath shared by multiply and divide.
// The 2*XLEN accumulator is split into a high half and a low half:
//   multiply : high = partial product, low = multiplier (shifted out LSB first)
//   divide   : high = partial remainder, low = dividend in / quotient out
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   load_i   in   load magnitudes: acc = {0, aMag_i}, operand = bMag_i
//   step_i   in   perform one iteration step
//   isDiv_i  in   1 = restoring divide step, 0 = shift-add multiply step
//   aMag_i   in   |rs1| (multiplier or dividend)
//   bMag_i   in   |rs2| (multiplicand or divisor)
//   acc_o    out  accumulator contents
// ---------------------------------------------------------------------------
module muldiv_dp #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              isDiv_i,
    input  logic [XLEN-1:0]   aMag_i,
    input  logic [XLEN-1:0]   bMag_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opB_q, opB_d;

    logic [XLEN-1:0]   accHi;
    logic [XLEN-1:0]   accLo;
    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     remShift;
    logic              remGeq;
    logic [XLEN-1:0]   remDiff;

    // Step arithmetic. The multiply adds the multiplicand into the high half
    // when the current multiplier LSB is set and then the whole accumulator
    // (including the adder carry) shifts right by one.  The divide shifts the
    // next dividend bit into the remainder and subtracts the divisor only when
    // it fits.  A successful subtraction always leaves a value below the
    // divisor, so an XLEN-wide difference is exact even though the shifted
    // remainder is XLEN+1 bits wide.
    always_comb begin
        accHi    = acc_q[2*XLEN-1:XLEN];
        accLo    = acc_q[XLEN-1:0];
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB_q} : {(XLEN+1){1'b0}});
        remShift = {accHi, accLo[XLEN-1]};
        remGeq   = (remShift >= {1'b0, opB_q});
        remDiff  = remShift[XLEN-1:0] - opB_q;

        acc_d = acc_q;
        opB_d = opB_q;
        if (load_i) begin
            acc_d = {{XLEN{1'b0}}, aMag_i};
            opB_d = bMag_i;
        end else if (step_i) begin
            if (isDiv_i) begin
                if (remGeq) begin
                    acc_d = {remDiff, accLo[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = {remShift[XLEN-1:0], accLo[XLEN-2:0], 1'b0};
                end
            end else begin
                acc_d = {mulSum, accLo[XLEN-1:1]};
            end
        end
    end

    // Datapath registers; cleared on reset so no stale operand survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            opB_q <= '0;
        end else begin
            acc_q <= acc_d;
            opB_q <= opB_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Iterative RV32M multiply/divide unit for the execute stage.  It captures an
// M-op held in EX, stalls the front of the pipeline while iterating, and
// presents the result together with a one-cycle DoneE strobe.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   StartE     in   M-op present in EX (held while EX is stalled)
//   MulDivOpE  in   operation (md_op_t, funct3 encoding)
//   SrcAE      in   rs1 operand
//   SrcBE      in   rs2 operand
//   RdE        in   destination register
//   FlushE     in   kill the EX instruction / abort a running op
//   StallE     out  hold IF/ID/EX (combinational)
//   DoneE      out  result valid strobe (one cycle)
//   MDResultE  out  result, valid while DoneE=1
//   MDRdE      out  destination register of the result
// ---------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StartE,
    input  md_op_t          MulDivOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic [4:0]      RdE,
    input  logic            FlushE,
    output logic            StallE,
    output logic            DoneE,
    output logic [XLEN-1:0] MDResultE,
    output logic [4:0]      MDRdE
);

    localparam int             CW       = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    md_op_t            op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   srcA_q, srcA_d;
    logic              negRes_q, negRes_d;
    logic              negRem_q, negRem_d;
    logic              divZero_q, divZero_d;
    logic              ovf_q, ovf_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        mdRd_q, mdRd_d;

    logic              aNeg, bNeg;
    logic [XLEN-1:0]   aMag, bMag;
    logic              inDivZero, inOvf, fastPath, startGo;
    logic              dpLoad, dpStep;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] prodFix;
    logic [XLEN-1:0]   quotFix, remFix, finResult;

    muldiv_dp #(.XLEN(XLEN)) u_dp (
        .clk     (clk),
        .reset   (reset),
        .load_i  (dpLoad),
        .step_i  (dpStep),
        .isDiv_i (is_div(op_q)),
        .aMag_i  (aMag),
        .bMag_i  (bMag),
        .acc_o   (acc)
    );

    // Operand preparation at issue: the datapath only sees magnitudes, so the
    // sign of each signed operand position is stripped here and remembered.
    // Division by zero and the single signed overflow case are detected on the
    // raw operands so they can skip the iteration when the fast path is on.
    always_comb begin
        aNeg      = a_signed(MulDivOpE) & SrcAE[XLEN-1];
        bNeg      = b_signed(MulDivOpE) & SrcBE[XLEN-1];
        aMag      = aNeg ? -SrcAE : SrcAE;
        bMag      = bNeg ? -SrcBE : SrcBE;
        inDivZero = is_div(MulDivOpE) && (SrcBE == '0);
        inOvf     = ((MulDivOpE == MD_DIV) || (MulDivOpE == MD_REM)) &&
                    (SrcAE == MIN_NEG) && (SrcBE == '1);
        fastPath  = FAST_SPECIAL && (inDivZero || inOvf);
        startGo   = StartE && !FlushE;
        dpLoad    = (state_q == ST_IDLE) && startGo;
        dpStep    = (state_q == ST_CALC) && !FlushE;
    end

    // Sign correction and result selection from the finished accumulator.
    // Quotient and product take the XOR of the operand signs; the remainder
    // follows the dividend.  The special cases override whatever the
    // accumulator holds, which also covers a full-length zero-divisor run.
    always_comb begin
        prodFix = negRes_q ? -acc : acc;
        quotFix = negRes_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        remFix  = negRem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        finResult = '0;
        case (op_q)
            MD_MUL:                       finResult = prodFix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: finResult = prodFix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU: begin
                if (divZero_q)  finResult = '1;
                else if (ovf_q) finResult = MIN_NEG;
                else            finResult = quotFix;
            end
            MD_REM, MD_REMU: begin
                if (divZero_q)  finResult = srcA_q;
                else if (ovf_q) finResult = '0;
                else            finResult = remFix;
            end
            default:                      finResult = '0;
        endcase
    end

    // FSM next-state logic.  A flush always returns to IDLE and blocks the
    // result register update, so an aborted op never produces DoneE nor
    // disturbs the previously delivered result.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        srcA_d    = srcA_q;
        negRes_d  = negRes_q;
        negRem_d  = negRem_q;
        divZero_d = divZero_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        mdRd_d    = mdRd_q;

        if (FlushE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (StartE) begin
                        op_d      = MulDivOpE;
                        rd_d      = RdE;
                        srcA_d    = SrcAE;
                        negRes_d  = aNeg ^ bNeg;
                        negRem_d  = aNeg;
                        divZero_d = inDivZero;
                        ovf_d     = inOvf;
                        cnt_d     = '0;
                        state_d   = fastPath ? ST_FINISH : ST_CALC;
                    end
                end
                ST_CALC: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    result_d = finResult;
                    mdRd_d   = rd_q;
                    state_d  = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= MD_MUL;
            rd_q      <= '0;
            srcA_q    <= '0;
            negRes_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            mdRd_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            srcA_q    <= srcA_d;
            negRes_q  <= negRes_d;
            negRem_q  <= negRem_d;
            divZero_q <= divZero_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            mdRd_q    <= mdRd_d;
        end
    end

    // StallE includes the issue cycle so the op stays in EX until DONE.
    // Gating with reset keeps the pipeline free while reset is asserted,
    // even if EX still presents an M-op.
    always_comb begin
        StallE = reset && (((state_q == ST_IDLE) && StartE && !FlushE) ||
                           (state_q == ST_CALC) || (state_q == ST_FINISH));
        DoneE  = (state_q == ST_DONE);
    end

    assign MDResultE = result_q;
    assign MDRdE     = mdRd_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed self-checking bench for muldiv_sequencer (XLEN=32, fast path on).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.  Cycle 0 is the cycle in which StartE is first presented.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        StartE;
    md_op_t      MulDivOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [4:0]  RdE;
    logic        FlushE;
    logic        StallE;
    logic        DoneE;
    logic [31:0] MDResultE;
    logic [4:0]  MDRdE;

    int vectors;
    int miscompares;

    muldiv_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .StartE    (StartE),
        .MulDivOpE (MulDivOpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .RdE       (RdE),
        .FlushE    (FlushE),
        .StallE    (StallE),
        .DoneE     (DoneE),
        .MDResultE (MDResultE),
        .MDRdE     (MDRdE)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op and follow it until DoneE (bounded at 100 cycles).
    // stallOk stays 1 only if StallE was high every cycle before DoneE and
    // low in the DoneE cycle.  doneCycle is -1 on timeout.
    task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res,
                          output logic [4:0] rdOut, output int doneCycle, output bit stallOk);
        bit seen;
        seen      = 1'b0;
        stallOk   = 1'b1;
        doneCycle = -1;
        res       = '0;
        rdOut     = '0;
        @(posedge clk); #1;
        StartE    = 1'b1;
        MulDivOpE = op;
        SrcAE     = a;
        SrcBE     = b;
        RdE       = rd;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (DoneE) begin
                seen      = 1'b1;
                doneCycle = c;
                res       = MDResultE;
                rdOut     = MDRdE;
                if (StallE) stallOk = 1'b0;
                StartE    = 1'b0;
                break;
            end else if (!StallE) begin
                stallOk = 1'b0;
            end
        end
        if (!seen) StartE = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (DoneE !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", DoneE); end
        vectors++; if (StallE !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %b expected 0", StallE); end
        vectors++; if (MDResultE !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_result: got %h expected 00000000", MDResultE); end
        vectors++; if (MDRdE !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_rd: got %0d expected 0", MDRdE); end
        StartE = 1'b1;
        #1;
        vectors++; if (StallE !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall_start: got %b expected 0", StallE); end
        StartE = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] r; logic [4:0] rd; int dc; bit sok;
        run_op(MD_MUL, 32'd7, 32'hFFFF_FFFD, 5'd11, r, rd, dc, sok);
        vectors++; if (r !== 32'hFFFF_FFEB) begin miscompares++; $display("[TB] FAIL mul_result: got %h expected ffffffeb", r); end
        vectors++; if (dc !== 34) begin miscompares++; $display("[TB] FAIL mul_latency: got %0d expected 34", dc); end
        vectors++; if (sok !== 1'b1) begin miscompares++; $display("[TB] FAIL mul_stall: got %b expected 1", sok); end
        vectors++; if (rd !== 5'd11) begin miscompares++; $display("[TB] FAIL mul_rd: got %0d expected 11", rd); end
    endtask

    task automatic test_mul_high();
        logic [31:0] r; logic [4:0] rd; int dc; bit sok;
        run_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, r, rd, dc, sok);
        vectors++; if (r !== 32'hFFFF_FFFE) begin miscompares++; $display("[TB] FAIL mulhu_result: got %h expected fffffffe", r); end
        run_op(MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, r, rd, dc, sok);
        vectors++; if (r !== 32'h0000_0000) begin miscompares++; $display("[TB] FAIL mulh_result: got %h expected 00000000", r); end
        run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd3, r, rd, dc, sok);
        vectors++; if (r !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL mulhsu_result: got %h expected ffffffff", r); end
        vectors++; if (rd !== 5'd3) begin miscompares++; $display("[TB] FAIL mulhsu_rd: got %0d expected 3", rd); end
    endtask

    task automatic test_div();
        logic [31:0] r; logic [4:0] rd; int dc; bit sok;
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, r, rd, dc, sok);
        vectors++; if (r !== 32'hFFFF_FFFD) begin miscompares++; $display("[TB] FAIL div_result: got %h expected fffffffd", r); end
        vectors++; if (dc !== 34) begin miscompares++; $display("[TB] FAIL div_latency: got %0d expected 34", dc); end
        run_op(MD_REM, 32'hFFFF_FFF9, 32'd2, 5'd5, r, rd, dc, sok);
        vectors++; if (r !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL rem_result: got %h expected ffffffff", r); end
        run_op(MD_DIVU, 32'd100, 32'd7, 5'd6, r, rd, dc, sok);
        vectors++; if (r !== 32'd14) begin miscompares++; $display("[TB] FAIL divu_result: got %h expected 0000000e", r); end
        run_op(MD_REMU, 32'd100, 32'd7, 5'd7, r, rd, dc, sok);
        vectors++; if (r !== 32'd2) begin miscompares++; $display("[TB] FAIL remu_result: got %h expected 00000002", r); end
        vectors++; if (sok !== 1'b1) begin miscompares++; $display("[TB] FAIL remu_stall: got %b expected 1", sok); end
    endtask

    task automatic test_fast_path();
        logic [31:0] r; logic [4:0] rd; int dc; bit sok;
        run_op(MD_DIVU, 32'd5, 32'd0, 5'd8, r, rd, dc, sok);
        vectors++; if (r !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL divu_zero_result: got %h expected ffffffff", r); end
        vectors++; if (dc !== 2) begin miscompares++; $display("[TB] FAIL divu_zero_latency: got %0d expected 2", dc); end
        vectors++; if (sok !== 1'b1) begin miscompares++; $display("[TB] FAIL divu_zero_stall: got %b expected 1", sok); end
        run_op(MD_REM, 32'd5, 32'd0, 5'd9, r, rd, dc, sok);
        vectors++; if (r !== 32'd5) begin miscompares++; $display("[TB] FAIL rem_zero_result: got %h expected 00000005", r); end
        vectors++; if (dc !== 2) begin miscompares++; $display("[TB] FAIL rem_zero_latency: got %0d expected 2", dc); end
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, r, rd, dc, sok);
        vectors++; if (r !== 32'h8000_0000) begin miscompares++; $display("[TB] FAIL div_ovf_result: got %h expected 80000000", r); end
        vectors++; if (dc !== 2) begin miscompares++; $display("[TB] FAIL div_ovf_latency: got %0d expected 2", dc); end
        run_op(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, r, rd, dc, sok);
        vectors++; if (r !== 32'h0000_0000) begin miscompares++; $display("[TB] FAIL rem_ovf_result: got %h expected 00000000", r); end
        vectors++; if (dc !== 2) begin miscompares++; $display("[TB] FAIL rem_ovf_latency: got %0d expected 2", dc); end
    endtask

    task automatic test_flush();
        logic [31:0] r; logic [4:0] rd; int dc; bit sok; int doneCount;
        @(posedge clk); #1;
        StartE    = 1'b1;
        MulDivOpE = MD_MUL;
        SrcAE     = 32'd5;
        SrcBE     = 32'd6;
        RdE       = 5'd13;
        // Advance to cycle 11, where the op is in CALC with cnt=10.
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
        end
        FlushE = 1'b1;
        @(posedge clk); #1;
        FlushE = 1'b0;
        StartE = 1'b0;
        @(negedge clk);
        vectors++; if (StallE !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_stall: got %b expected 0", StallE); end
        doneCount = 0;
        for (int c = 0; c < 40; c++) begin
            if (DoneE) doneCount++;
            @(negedge clk);
        end
        vectors++; if (doneCount !== 0) begin miscompares++; $display("[TB] FAIL flush_no_done: got %0d strobes expected 0", doneCount); end
        run_op(MD_MUL, 32'd3, 32'd4, 5'd14, r, rd, dc, sok);
        vectors++; if (r !== 32'd12) begin miscompares++; $display("[TB] FAIL flush_next_result: got %h expected 0000000c", r); end
        vectors++; if (dc !== 34) begin miscompares++; $display("[TB] FAIL flush_next_latency: got %0d expected 34", dc); end
    endtask

    task automatic test_async_reset();
        logic [31:0] r; logic [4:0] rd; int dc; bit sok;
        @(posedge clk); #1;
        StartE    = 1'b1;
        MulDivOpE = MD_DIV;
        SrcAE     = 32'd1000;
        SrcBE     = 32'd7;
        RdE       = 5'd15;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
        end
        #3;
        reset = 1'b0;
        #1;
        vectors++; if (StallE !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_stall: got %b expected 0", StallE); end
        vectors++; if (DoneE !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_done: got %b expected 0", DoneE); end
        vectors++; if (MDResultE !== 32'h0) begin miscompares++; $display("[TB] FAIL areset_result: got %h expected 00000000", MDResultE); end
        vectors++; if (MDRdE !== 5'd0) begin miscompares++; $display("[TB] FAIL areset_rd: got %0d expected 0", MDRdE); end
        StartE = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        run_op(MD_DIVU, 32'd9, 32'd3, 5'd16, r, rd, dc, sok);
        vectors++; if (r !== 32'd3) begin miscompares++; $display("[TB] FAIL areset_divu_result: got %h expected 00000003", r); end
        vectors++; if (dc !== 34) begin miscompares++; $display("[TB] FAIL areset_divu_latency: got %0d expected 34", dc); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        StartE      = 1'b0;
        MulDivOpE   = MD_MUL;
        SrcAE       = '0;
        SrcBE       = '0;
        RdE         = '0;
        FlushE      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] starting muldiv_sequencer directed tests");
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_fast_path();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
